// File: rtl/reg_wb_queue.sv
// ---------------------------------------------------------------------------
// reg_wb_queue
//
// Write-side front end of the register file. Writeback results from the WB
// stage are buffered in an in-order queue. One entry drains per cycle into
// the registered register-file write port (rf_*). Optional youngest-match
// forwarding serves the decode-stage RS/RT readers.
//
// Build option:
//   WBQ_FWD_EN  defined   -> RS/RT lookups compare against every valid queue
//                            entry and the rf_* stage; the youngest match wins.
//               undefined -> no compare logic; hit/data outputs are tied to 0.
//
// Parameters:
//   DEPTH  queue entries (power of two, >= 2)
//   AW     register address width
//   DW     register data width
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   wb_valid_i/_ready_o       writeback handshake (ready = !full)
//   wb_addr_i, wb_data_i      writeback destination and result
//   rf_we_o/_addr_o/_data_o   registered register-file write port
//   rs_addr_i, rt_addr_i      decode lookup addresses
//   rs_hit_o/_data_o          RS forwarding result (data 0 on miss)
//   rt_hit_o/_data_o          RT forwarding result (data 0 on miss)
//   count_o, empty_o, full_o  queue occupancy
// ---------------------------------------------------------------------------
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wb_valid_i,
    output logic                       wb_ready_o,
    input  logic [AW-1:0]              wb_addr_i,
    input  logic [DW-1:0]              wb_data_i,
    output logic                       rf_we_o,
    output logic [AW-1:0]              rf_addr_o,
    output logic [DW-1:0]              rf_data_o,
    input  logic [AW-1:0]              rs_addr_i,
    input  logic [AW-1:0]              rt_addr_i,
    output logic                       rs_hit_o,
    output logic [DW-1:0]              rs_data_o,
    output logic                       rt_hit_o,
    output logic [DW-1:0]              rt_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_data_q, rf_data_d;

    logic full, accept, push, pop;

    // Occupancy alone decides full/empty; pointers only index storage.
    assign full   = (count_q == CW'(DEPTH));
    assign accept = wb_valid_i & ~full;
    // Register 0 is never written, so it is accepted and then dropped.
    assign push   = accept & (wb_addr_i != '0);
    // Drain never stalls: the head leaves whenever anything is queued.
    // An entry pushed this edge is never the one popped this edge.
    assign pop    = (count_q != '0);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rf_we_d   = 1'b1;
            rf_addr_d = addr_q[rd_ptr_q];
            rf_data_d = data_q[rd_ptr_q];
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Storage needs no reset: entries beyond count_q are never observed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            addr_q[wr_ptr_q] <= wb_addr_i;
            data_q[wr_ptr_q] <= wb_data_i;
        end
    end

    assign wb_ready_o = ~full;
    assign rf_we_o    = rf_we_q;
    assign rf_addr_o  = rf_addr_q;
    assign rf_data_o  = rf_data_q;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = full;

`ifdef WBQ_FWD_EN
    // Returns {hit, data}. Scanning goes from oldest to youngest, so later
    // matches overwrite earlier ones. The rf_* stage is older than every
    // queued entry, so it is checked first.
    function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
        logic [DW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        idx = '0;
        if (a != '0) begin
            if (rf_we_q && rf_addr_q == a) res = {1'b1, rf_data_q};
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if (CW'(i) < count_q && addr_q[idx] == a) res = {1'b1, data_q[idx]};
            end
        end
        return res;
    endfunction

    logic [DW:0] rs_res, rt_res;
    assign rs_res    = lookup(rs_addr_i);
    assign rt_res    = lookup(rt_addr_i);
    assign rs_hit_o  = rs_res[DW];
    assign rs_data_o = rs_res[DW-1:0];
    assign rt_hit_o  = rt_res[DW];
    assign rt_data_o = rt_res[DW-1:0];
`else
    // Decode relies on empty_o to stall, so the lookup addresses go unused.
    logic unused_lookup;
    assign unused_lookup = ^{rs_addr_i, rt_addr_i};
    assign rs_hit_o  = 1'b0;
    assign rs_data_o = '0;
    assign rt_hit_o  = 1'b0;
    assign rt_data_o = '0;
`endif

endmodule
